vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator. A pixel-clock divider drives
//               horizontal and vertical position counters. Sync, active-area
//               and strobe outputs are all registered and aligned with the
//               position shown in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIX_DIV   = 2,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  output logic [XW-1:0] hpos,
  output logic [YW-1:0] vpos,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          pix_stb,
  output logic          frame_start,
  output logic          line_start
);

  // Divider width; a PIX_DIV of 1 still keeps a 1-bit counter that stays at 0.
  localparam int              c_dw         = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [c_dw-1:0] c_dmax       = c_dw'(PIX_DIV - 1);
  localparam logic [XW-1:0]   c_hmax       = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]   c_vmax       = YW'(V_TOTAL - 1);

  // Decode boundaries are kept 32 bits wide so an end value equal to the
  // total count (zero back porch) cannot overflow the counter width.
  localparam logic [31:0]     c_h_active   = 32'(H_ACTIVE);
  localparam logic [31:0]     c_v_active   = 32'(V_ACTIVE);
  localparam logic [31:0]     c_hs_start   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]     c_hs_end     = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]     c_vs_start   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]     c_vs_end     = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_dw-1:0] r_dcnt;

  logic            w_advance;
  logic            w_dwrap;
  logic            w_hwrap;
  logic [c_dw-1:0] w_dcnt_nxt;
  logic [XW-1:0]   w_hpos_nxt;
  logic [YW-1:0]   w_vpos_nxt;
  logic            w_hs_on;
  logic            w_vs_on;
  logic            w_act_on;
  logic            w_pix_first;

  // Next position: counters only move while already running; entering RUN
  // or idling both present position (0,0) with the divider at 0.
  always_comb begin
    w_advance  = run && (r_state == ST_RUN);
    w_dwrap    = (r_dcnt == c_dmax);
    w_hwrap    = w_dwrap && (hpos == c_hmax);
    w_dcnt_nxt = '0;
    w_hpos_nxt = '0;
    w_vpos_nxt = '0;
    if (w_advance) begin
      w_dcnt_nxt = w_dwrap ? '0 : r_dcnt + 1'b1;
      if (w_dwrap) begin
        w_hpos_nxt = w_hwrap ? '0 : hpos + 1'b1;
      end else begin
        w_hpos_nxt = hpos;
      end
      if (w_hwrap) begin
        w_vpos_nxt = (vpos == c_vmax) ? '0 : vpos + 1'b1;
      end else begin
        w_vpos_nxt = vpos;
      end
    end
    w_hs_on     = (32'(w_hpos_nxt) >= c_hs_start) && (32'(w_hpos_nxt) < c_hs_end);
    w_vs_on     = (32'(w_vpos_nxt) >= c_vs_start) && (32'(w_vpos_nxt) < c_vs_end);
    w_act_on    = (32'(w_hpos_nxt) < c_h_active) && (32'(w_vpos_nxt) < c_v_active);
    w_pix_first = (w_dcnt_nxt == '0);
  end

  // State, counters and decoded outputs all register together so every
  // output in a cycle describes the position shown in that same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dcnt      <= '0;
      hpos        <= '0;
      vpos        <= '0;
      active      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pix_stb     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      r_state     <= run ? ST_RUN : ST_IDLE;
      r_dcnt      <= w_dcnt_nxt;
      hpos        <= w_hpos_nxt;
      vpos        <= w_vpos_nxt;
      active      <= run && w_act_on;
      hsync       <= (run && w_hs_on) ? HS_POL : ~HS_POL;
      vsync       <= (run && w_vs_on) ? VS_POL : ~VS_POL;
      pix_stb     <= run && w_pix_first;
      line_start  <= run && w_pix_first && (w_hpos_nxt == '0);
      frame_start <= run && w_pix_first && (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
    end
  end

endmodule
`default_nettype wire
